// File: rtl/cla_bist_if.sv
// Operand/result pins between the BIST sequencer and the cla adder macro.
interface cla_bist_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] a_o;
  logic [WIDTH-1:0] b_o;
  logic             cin_o;
  logic [WIDTH-1:0] s_i;
  logic             cout_i;

  modport master (
    output a_o, b_o, cin_o,
    input  s_i, cout_i
  );

  modport slave (
    input  a_o, b_o, cin_o,
    output s_i, cout_i
  );
endinterface

// File: rtl/cla_bist.sv
// Exhaustive BIST sweep for the cla adder: drive {cin,b,a}, settle,
// sample {cout,s} and compare with a reference sum.
module cla_bist #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 2
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_ni,
  input  logic               start_i,
  input  logic               abort_i,
  cla_bist_if.master         adr,
  output logic               busy_o,
  output logic               done_o,
  output logic               pass_o,
  output logic [7:0]         err_cnt_o,
  output logic [2*WIDTH:0]   fail_vec_o,
  output logic [WIDTH:0]     fail_got_o
);

  localparam int NW = 2 * WIDTH + 1;
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  state_t          r_state;
  logic [NW-1:0]   r_cnt;
  logic [SW-1:0]   r_sc;
  logic            r_busy;
  logic            r_done;
  logic            r_pass;
  logic [7:0]      r_err;
  logic [NW-1:0]   r_fvec;
  logic [WIDTH:0]  r_fgot;

  logic [WIDTH:0]  w_ref;
  logic [WIDTH:0]  w_got;
  logic            w_mis;
  logic [7:0]      w_err_nxt;
  logic            w_run;

  assign {adr.cin_o, adr.b_o, adr.a_o} = r_cnt;

  assign w_ref = {1'b0, adr.a_o}
               + {1'b0, adr.b_o}
               + {{WIDTH{1'b0}}, adr.cin_o};
  assign w_got = {adr.cout_i, adr.s_i};
  assign w_mis = (w_ref != w_got);
  assign w_err_nxt = (w_mis && r_err != 8'hFF)
                   ? r_err + 8'd1 : r_err;
  assign w_run = (r_state == S_DRIVE)
              || (r_state == S_SETTLE)
              || (r_state == S_CHECK);

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_sc    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_err   <= '0;
      r_fvec  <= '0;
      r_fgot  <= '0;
    end else if (abort_i && w_run) begin
      // abort wins over a same-cycle finish; error status is kept
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            r_state <= S_DRIVE;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_err   <= '0;
            r_fvec  <= '0;
            r_fgot  <= '0;
          end
        end
        S_DRIVE: begin
          if (SETTLE > 0) begin
            r_state <= S_SETTLE;
            r_sc    <= SW'(SETTLE - 1);
          end else begin
            r_state <= S_CHECK;
          end
        end
        S_SETTLE: begin
          if (r_sc == '0) r_state <= S_CHECK;
          else            r_sc    <= r_sc - SW'(1);
        end
        S_CHECK: begin
          r_err <= w_err_nxt;
          if (w_mis && r_err == 8'd0) begin
            r_fvec <= r_cnt;
            r_fgot <= w_got;
          end
          if (&r_cnt) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_err_nxt == 8'd0);
          end else begin
            r_state <= S_DRIVE;
            r_cnt   <= r_cnt + NW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy_o     = r_busy;
  assign done_o     = r_done;
  assign pass_o     = r_pass;
  assign err_cnt_o  = r_err;
  assign fail_vec_o = r_fvec;
  assign fail_got_o = r_fgot;

endmodule

// File: tb/tb_cla_bist.sv
// Bench for cla_bist: behavioural adder with fault modes, two DUTs
// (SETTLE=2 and SETTLE=0), scenario table plus abort/reset sequences.
module tb_cla_bist;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] start = '0;
  logic [1:0] abort = '0;
  int mode [2];

  logic [1:0]       busy, done, pass;
  logic [1:0][7:0]  err;
  logic [1:0][8:0]  fvec;
  logic [1:0][4:0]  fgot;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cla_bist_if #(.WIDTH(4)) if0 ();
  cla_bist_if #(.WIDTH(4)) if1 ();

  function automatic logic [4:0] adder(
    logic c, logic [3:0] b, logic [3:0] a, int m);
    logic [4:0] r;
    logic [8:0] v;
    r = {1'b0, a} + {1'b0, b} + {4'b0, c};
    v = {c, b, a};
    if (m == 1 && v == 9'h053) r[2] = ~r[2];
    if (m == 2) r[0] = 1'b0;
    return r;
  endfunction

  assign {if0.cout_i, if0.s_i} =
    adder(if0.cin_o, if0.b_o, if0.a_o, mode[0]);
  assign {if1.cout_i, if1.s_i} =
    adder(if1.cin_o, if1.b_o, if1.a_o, mode[1]);

  cla_bist #(.WIDTH(4), .SETTLE(2)) u0 (
    .wb_clk_i   (clk),
    .wb_rst_ni  (rst_n),
    .start_i    (start[0]),
    .abort_i    (abort[0]),
    .adr        (if0),
    .busy_o     (busy[0]),
    .done_o     (done[0]),
    .pass_o     (pass[0]),
    .err_cnt_o  (err[0]),
    .fail_vec_o (fvec[0]),
    .fail_got_o (fgot[0])
  );

  cla_bist #(.WIDTH(4), .SETTLE(0)) u1 (
    .wb_clk_i   (clk),
    .wb_rst_ni  (rst_n),
    .start_i    (start[1]),
    .abort_i    (abort[1]),
    .adr        (if1),
    .busy_o     (busy[1]),
    .done_o     (done[1]),
    .pass_o     (pass[1]),
    .err_cnt_o  (err[1]),
    .fail_vec_o (fvec[1]),
    .fail_got_o (fgot[1])
  );

  typedef struct {
    int       d;
    int       m;
    bit       restart;
    int       cycles;
    bit       pass;
    int       err;
    int       fvec;
    int       fgot;
  } scn_t;

  typedef struct {
    int cycles;
    int pass;
    int err;
    int fvec;
    int fgot;
  } exp_t;

  exp_t sb [$];
  scn_t tbl [6];

  task automatic chk(string n, int got, int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", n, got, exp);
    end
  endtask

  function automatic int ops(int d);
    if (d == 0) return {if0.cin_o, if0.b_o, if0.a_o};
    return {if1.cin_o, if1.b_o, if1.a_o};
  endfunction

  // start at the next edge; returns with #1 past that edge
  task automatic kick(int d);
    @(negedge clk);
    start[d] = 1'b1;
    @(posedge clk);
    #1;
    start[d] = 1'b0;
  endtask

  task automatic run_scn(scn_t s);
    exp_t e;
    exp_t q;
    int cyc;
    mode[s.d] = s.m;
    e.cycles = s.cycles;
    e.pass   = s.pass;
    e.err    = s.err;
    e.fvec   = s.fvec;
    e.fgot   = s.fgot;
    sb.push_back(e);
    kick(s.d);
    chk("busy_after_start", busy[s.d], 1);
    chk("done_after_start", done[s.d], 0);
    cyc = 0;
    while (!done[s.d] && cyc < 3000) begin
      @(posedge clk);
      #1;
      cyc++;
      start[s.d] = (s.restart && cyc == 300);
    end
    start[s.d] = 1'b0;
    q = sb.pop_front();
    chk("sweep_cycles", cyc, q.cycles);
    chk("pass", pass[s.d], q.pass);
    chk("err_cnt", err[s.d], q.err);
    chk("fail_vec", fvec[s.d], q.fvec);
    chk("fail_got", fgot[s.d], q.fgot);
    chk("busy_at_done", busy[s.d], 0);
  endtask

  initial begin
    mode[0] = 0;
    mode[1] = 0;
    tbl[0] = '{0, 0, 1'b0, 2048, 1'b1,   0, 'h000, 'h00};
    tbl[1] = '{0, 1, 1'b0, 2048, 1'b0,   1, 'h053, 'h0C};
    tbl[2] = '{0, 2, 1'b0, 2048, 1'b0, 255, 'h001, 'h00};
    tbl[3] = '{1, 0, 1'b1, 1024, 1'b1,   0, 'h000, 'h00};
    tbl[4] = '{1, 1, 1'b0, 1024, 1'b0,   1, 'h053, 'h0C};
    tbl[5] = '{1, 2, 1'b1, 1024, 1'b0, 255, 'h001, 'h00};

    #12;
    chk("rst_busy", busy[0], 0);
    chk("rst_done", done[0], 0);
    chk("rst_ops", ops(0), 0);
    chk("rst_err", err[0], 0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_scn(tbl[i]);

    // abort at cycle 100, then a clean full sweep
    mode[0] = 0;
    kick(0);
    repeat (99) @(posedge clk);
    #1;
    abort[0] = 1'b1;
    @(posedge clk);
    #1;
    abort[0] = 1'b0;
    chk("abort_busy", busy[0], 0);
    chk("abort_done", done[0], 0);
    chk("abort_ops", ops(0), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_stays_idle", busy[0], 0);
    run_scn(tbl[0]);

    // mid-sweep async reset after a first error was logged
    mode[0] = 1;
    kick(0);
    repeat (4) @(posedge clk);
    #1;
    chk("ops_vec1", ops(0), 1);
    repeat (396) @(posedge clk);
    #1;
    chk("err_before_rst", err[0], 1);
    chk("fvec_before_rst", fvec[0], 'h053);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy[0], 0);
    chk("arst_ops", ops(0), 0);
    chk("arst_err", err[0], 0);
    chk("arst_fvec", fvec[0], 0);
    chk("arst_fgot", fgot[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("idle_after_rst", busy[0], 0);
    chk("idle_ops", ops(0), 0);

    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
